// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU (opcodes, flag bundle, FSM states).
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_XOR = 3'b001,
    ALU_SUB = 3'b010,
    ALU_SLT = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_SLL = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic c;
    logic z;
    logic v;
    logic n;
  } alu_flags_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one multiplier bit per clock.
// A start pulse loads the operands; done rises WIDTH cycles later and the
// low WIDTH bits of the product sit on 'product' for that cycle.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;

  assign done    = active_q && (cnt_q == CW'(WIDTH));
  assign product = acc_q;

  // Load on start, otherwise add-and-shift one bit per cycle until the count completes.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (done) begin
      active_d = 1'b0;
    end else if (active_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  // Multiplier state registers; reset abandons any product in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes on input and output.
// Define ALU_SEQ_MUL_EN to make op 111 an iterative multiply (WIDTH+1 cycle latency);
// without it op 111 completes in one cycle with a zero result.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SLT_SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             negative
);
  localparam int SHW = $clog2(WIDTH);

  alu_op_t          op_e;
  logic [WIDTH-1:0] alu_res;
  alu_flags_t       alu_flags;
  logic [WIDTH:0]   sum_ext;
  logic             slt_lt;
  logic             accept;

  alu_state_t       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;

  assign in_ready = rst_n && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign mul_start = accept && (op_e == ALU_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  // Single-cycle datapath: result and flags for every op except the multiply.
  always_comb begin
    op_e      = alu_op_t'(op);
    alu_res   = '0;
    alu_flags = '0;
    sum_ext   = '0;
    slt_lt    = 1'b0;
    case (op_e)
      ALU_ADD: begin
        sum_ext     = {1'b0, a} + {1'b0, b};
        alu_res     = sum_ext[WIDTH-1:0];
        alu_flags.c = sum_ext[WIDTH];
        alu_flags.v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_XOR: alu_res = a ^ b;
      ALU_SUB: begin
        sum_ext     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        alu_res     = sum_ext[WIDTH-1:0];
        alu_flags.c = sum_ext[WIDTH];
        alu_flags.v = (a[WIDTH-1] != b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: begin
        if (SLT_SIGNED) slt_lt = $signed(a) < $signed(b);
        else            slt_lt = a < b;
        alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
      end
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      ALU_SLL: alu_res = a << b[SHW-1:0];
      default: alu_res = '0;
    endcase
    alu_flags.z = (alu_res == '0);
    alu_flags.n = alu_res[WIDTH-1];
  end

  // Handshake FSM: retire, accept, and load of the output register.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (op_e == ALU_MUL) begin
            state_d = MUL_BUSY;
          end else
`endif
          begin
            result_d    = alu_res;
            flags_d     = alu_flags;
            out_valid_d = 1'b1;
          end
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL_BUSY: begin
        if (mul_done) begin
          result_d    = mul_product;
          flags_d     = '{c: 1'b0, z: (mul_product == '0), v: 1'b0, n: mul_product[WIDTH-1]};
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything and drops any pending result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = flags_q.c;
  assign zero      = flags_q.z;
  assign overflow  = flags_q.v;
  assign negative  = flags_q.n;

endmodule
